// File: rtl/bpm_link_pkg.sv
// Shared definitions for the BPM link reader and its readout collector:
// status codes and the field layout of a validated 112-bit readout.
package bpm_link_pkg;

  localparam int READOUT_WIDTH = 112;
  localparam int PAYLOAD_WIDTH = 96;
  localparam int HEADER_LSB    = 96;
  localparam int X_LSB         = 64;
  localparam int Y_LSB         = 32;
  localparam int S_LSB         = 0;

  typedef enum logic [1:0] {
    ST_SUCCESS    = 2'd0,
    ST_BAD_HEADER = 2'd1,
    ST_BAD_SIZE   = 2'd2,
    ST_BAD_PACKET = 2'd3
  } status_code_e;

  localparam int NUM_STATUS_CODES = 4;

endpackage

// File: rtl/bpm_readout_ram.sv
// Simple dual-port RAM, one write port and one registered read port.
// A read and a write to the same address in one cycle return the old data.
module bpm_readout_ram #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 96
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_data_d;
  logic [DATA_WIDTH-1:0] rd_data_q;

  // Storage array writes; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Next read value is the pre-edge array content at rd_addr.
  always_comb begin
    rd_data_d = mem[rd_addr];
  end

  // Read register; reset so the output comes up as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else begin
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/bpm_readout_collector.sv
// Collects validated BPM readouts into a per-BPM table, tracks which BPMs
// have reported in the current acquisition cycle, flags cycle completion
// and keeps saturating reception statistics.
module bpm_readout_collector
  import bpm_link_pkg::*;
#(
  parameter int BPM_INDEX_WIDTH = 9,
  parameter int COUNTER_WIDTH   = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cycleStart,
  input  logic [BPM_INDEX_WIDTH:0]     expectedCount,
  input  logic                         bpmStrobe,
  input  logic [READOUT_WIDTH-1:0]     bpmData,
  input  logic                         statusStrobe,
  input  logic [1:0]                   statusCode,
  input  logic                         countsClear,
  input  logic [BPM_INDEX_WIDTH-1:0]   rdAddr,
  output logic [PAYLOAD_WIDTH-1:0]     rdData,
  output logic                         rdSeen,
  output logic [BPM_INDEX_WIDTH:0]     seenCount,
  output logic                         cycleComplete,
  output logic [4*COUNTER_WIDTH-1:0]   statusCounts,
  output logic [COUNTER_WIDTH-1:0]     duplicateCount,
  output logic [COUNTER_WIDTH-1:0]     rangeErrorCount
);

  localparam int NUM_BPM = 2**BPM_INDEX_WIDTH;
  localparam logic [COUNTER_WIDTH-1:0]   CNT_ONE  = COUNTER_WIDTH'(1);
  localparam logic [COUNTER_WIDTH-1:0]   CNT_MAX  = {COUNTER_WIDTH{1'b1}};
  localparam logic [BPM_INDEX_WIDTH:0]   SEEN_ONE = (BPM_INDEX_WIDTH+1)'(1);

  // Saturating counter step: clear wins first, then the increment applies.
  function automatic logic [COUNTER_WIDTH-1:0] sat_inc(
    input logic [COUNTER_WIDTH-1:0] cnt,
    input logic                     clr,
    input logic                     inc
  );
    logic [COUNTER_WIDTH-1:0] base;
    base = clr ? '0 : cnt;
    if (inc && (base != CNT_MAX)) begin
      return base + CNT_ONE;
    end else begin
      return base;
    end
  endfunction

  logic [BPM_INDEX_WIDTH-1:0] idx;
  logic                       out_of_range;
  logic                       accept;
  logic                       duplicate;
  logic                       range_err;
  logic                       hit;
  logic [NUM_BPM-1:0]         seen_base;
  logic [BPM_INDEX_WIDTH:0]   count_base;
  logic                       fired_base;

  logic [NUM_BPM-1:0]         seen_d,           seen_q;
  logic [BPM_INDEX_WIDTH:0]   seen_count_d,     seen_count_q;
  logic                       fired_d,          fired_q;
  logic                       hit_d,            hit_q;
  logic                       cycle_complete_d, cycle_complete_q;
  logic                       rd_seen_d,        rd_seen_q;
  logic [COUNTER_WIDTH-1:0]   status_d [NUM_STATUS_CODES];
  logic [COUNTER_WIDTH-1:0]   status_q [NUM_STATUS_CODES];
  logic [COUNTER_WIDTH-1:0]   dup_d,            dup_q;
  logic [COUNTER_WIDTH-1:0]   range_d,          range_q;

  assign idx          = bpmData[HEADER_LSB +: BPM_INDEX_WIDTH];
  assign out_of_range = |bpmData[READOUT_WIDTH-1 : HEADER_LSB+BPM_INDEX_WIDTH];

  // Acceptance, bitmap/seenCount update and completion detection.
  // A coincident cycleStart clears first so the readout lands in the new cycle.
  always_comb begin
    seen_base  = cycleStart ? '0   : seen_q;
    count_base = cycleStart ? '0   : seen_count_q;
    fired_base = cycleStart ? 1'b0 : fired_q;
    accept     = 1'b0;
    duplicate  = 1'b0;
    range_err  = 1'b0;
    if (bpmStrobe) begin
      if (out_of_range) begin
        range_err = 1'b1;
      end else if (seen_base[idx]) begin
        duplicate = 1'b1;
      end else begin
        accept = 1'b1;
      end
    end else begin
      accept = 1'b0;
    end
    seen_d       = seen_base;
    seen_count_d = count_base;
    if (accept) begin
      seen_d[idx]  = 1'b1;
      seen_count_d = count_base + SEEN_ONE;
    end else begin
      seen_count_d = count_base;
    end
    // Fires only on the edge where seenCount moves onto the target.
    hit = accept && (expectedCount != '0) && (seen_count_d == expectedCount) && !fired_base;
    fired_d          = fired_base | hit;
    hit_d            = hit;
    cycle_complete_d = hit_q;
    rd_seen_d        = seen_q[rdAddr];
  end

  // Statistics counter next values.
  always_comb begin
    for (int k = 0; k < NUM_STATUS_CODES; k++) begin
      status_d[k] = sat_inc(status_q[k], countsClear, statusStrobe && (statusCode == 2'(k)));
    end
    dup_d   = sat_inc(dup_q,   countsClear, duplicate);
    range_d = sat_inc(range_q, countsClear, range_err);
  end

  // Cycle-tracking and statistics registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seen_q           <= '0;
      seen_count_q     <= '0;
      fired_q          <= 1'b0;
      hit_q            <= 1'b0;
      cycle_complete_q <= 1'b0;
      rd_seen_q        <= 1'b0;
      for (int k = 0; k < NUM_STATUS_CODES; k++) begin
        status_q[k] <= '0;
      end
      dup_q            <= '0;
      range_q          <= '0;
    end else begin
      seen_q           <= seen_d;
      seen_count_q     <= seen_count_d;
      fired_q          <= fired_d;
      hit_q            <= hit_d;
      cycle_complete_q <= cycle_complete_d;
      rd_seen_q        <= rd_seen_d;
      for (int k = 0; k < NUM_STATUS_CODES; k++) begin
        status_q[k] <= status_d[k];
      end
      dup_q            <= dup_d;
      range_q          <= range_d;
    end
  end

  bpm_readout_ram #(
    .ADDR_WIDTH (BPM_INDEX_WIDTH),
    .DATA_WIDTH (PAYLOAD_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (accept),
    .wr_addr (idx),
    .wr_data (bpmData[PAYLOAD_WIDTH-1:0]),
    .rd_addr (rdAddr),
    .rd_data (rdData)
  );

  assign rdSeen          = rd_seen_q;
  assign seenCount       = seen_count_q;
  assign cycleComplete   = cycle_complete_q;
  assign duplicateCount  = dup_q;
  assign rangeErrorCount = range_q;
  assign statusCounts    = {status_q[3], status_q[2], status_q[1], status_q[0]};

endmodule

// File: doc/bpm_readout_collector.md
Name: bpm_readout_collector

Overview:
- Downstream stage of the BPM link reader, in the Aurora receiver AXI clock domain.
- Consumes validated 112-bit BPM readouts and per-packet status codes.
- Stores each readout in a per-BPM table indexed by the header's BPM number and tracks which BPMs have reported in the current fast-acquisition cycle.
- Flags cycle completion and keeps saturating reception statistics for the readback/CSR logic.

Parameters:
- BPM_INDEX_WIDTH, 9: table address width; the table holds 2**BPM_INDEX_WIDTH entries.
- COUNTER_WIDTH, 16: width of each statistics counter.

Ports:
- clk  in  1  Aurora receiver AXI clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- cycleStart  in  1  single-cycle pulse marking a new acquisition cycle; clears the seen bitmap and seenCount.
- expectedCount  in  BPM_INDEX_WIDTH+1  number of BPMs expected per cycle; 0 disables completion.
- bpmStrobe  in  1  readout valid, one cycle.
- bpmData  in  112  readout layout:
  - [111:96] header low half (BPM number)
  - [95:64] X
  - [63:32] Y
  - [31:0] S
- statusStrobe  in  1  status valid, one cycle.
- statusCode  in  2  status code: 0 success, 1 bad header, 2 bad size, 3 bad packet.
- countsClear  in  1  single-cycle pulse; zeroes all statistics counters.
- rdAddr  in  BPM_INDEX_WIDTH  table read address.
- rdData  out  96  {X,Y,S} stored at rdAddr, one cycle after rdAddr is presented.
- rdSeen  out  1  seen bit for rdAddr in the current cycle, aligned with rdData.
- seenCount  out  BPM_INDEX_WIDTH+1  distinct BPMs accepted in this cycle.
- cycleComplete  out  1  single-cycle pulse.
- statusCounts  out  4*COUNTER_WIDTH  per-code counters; code n occupies [n*COUNTER_WIDTH +: COUNTER_WIDTH].
- duplicateCount  out  COUNTER_WIDTH  readouts dropped because the BPM was already seen this cycle.
- rangeErrorCount  out  COUNTER_WIDTH  readouts dropped because the BPM index is out of range.

Behaviour:
- Reset: all outputs, counters, seen bitmap, seenCount and the rdData/rdSeen registers go to 0. Table RAM contents are not reset.
- Index decode:
  - idx = bpmData[96 +: BPM_INDEX_WIDTH].
  - Out of range if any bit of bpmData[111 : 96+BPM_INDEX_WIDTH] is 1.
- Accept rule, on bpmStrobe:
  - Out of range: rangeErrorCount += 1; no write.
  - Else if seen[idx] = 1: duplicateCount += 1; the stored value is kept (first arrival wins).
  - Else: write bpmData[95:0] to table[idx], set seen[idx], seenCount += 1.
  - All three effects take effect on the next edge.
- Completion: cycleComplete pulses for one cycle, on the cycle after seenCount transitions to equal a nonzero expectedCount. It pulses at most once per acquisition cycle; a later change to expectedCount does not re-fire it.
- cycleStart and bpmStrobe in the same cycle:
  - The clear applies first, then the readout is accepted into the new cycle: seenCount = 1 and only seen[idx] is set.
  - The completion latch is rearmed.
- Status counters: on statusStrobe, statusCounts[statusCode] += 1. All counters saturate at all-ones.
- countsClear and an increment in the same cycle: the counter ends at 1.
- countsClear affects neither the bitmap nor seenCount.
- Table is a simple dual-port RAM with registered read, 1-cycle latency.
  - Read and write to the same address in the same cycle: rdData returns the old data.
  - rdSeen reflects the bitmap state before that edge's update.
- bpmStrobe and statusStrobe are independent and may coincide; both are processed.
- No backpressure: every strobe is processed in the cycle it arrives.

Decomposition:
- Shared package (bpm_link_pkg):
  - status code constants ST_SUCCESS/ST_BAD_HEADER/ST_BAD_SIZE/ST_BAD_PACKET, shared with the link reader.
  - readout field offsets: HEADER_LSB=96, X_LSB=64, Y_LSB=32, S_LSB=0.
  - READOUT_WIDTH=112.
- One sub-module, bpm_readout_ram: parameterised simple dual-port RAM with registered read port.

Test Plan:
- Reset, then rdAddr=5 → rdData=0, rdSeen=0, seenCount=0, all counters 0.
- expectedCount=3; readouts for BPMs 2, 7, 9 with X=0x11111111 → seenCount 1,2,3; one cycleComplete pulse after the third; rdAddr=7 gives X=0x11111111 and rdSeen=1.
- Second readout for BPM 7 with X=0x22222222 → duplicateCount=1, table[7] X remains 0x11111111; then cycleStart together with a BPM 7 strobe → seenCount=1, seen[2]=0, and table[7] X becomes 0x22222222.
- Header 0x0200 with BPM_INDEX_WIDTH=9 → rangeErrorCount=1, no write, seenCount unchanged.
- 3 statusStrobe with code 2, then countsClear coincident with a code-2 strobe → statusCounts[2]=1. Force counter to 0xFFFF plus one strobe → stays 0xFFFF.
- Assert rst_n low mid-cycle with seenCount=2 → asynchronous clear: seenCount=0, no cycleComplete pulse after release.
